// File: rtl/usr_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | usr_pkg : shared encodings for the universal shift register and  |
// |           its command sequencer.                                 |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package usr_pkg;

    localparam int DEFAULT_WIDTH = 4;

    // Command op encoding doubles as the register MODE encoding.
    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/usr_seq_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | usr_seq_ctrl_if : command, serial-stream and register-side       |
// |                   signals of the sequencer.                      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface usr_seq_ctrl_if
    import usr_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_count;
    logic [WIDTH-1:0] cmd_data;

    logic             ser_in_valid;
    logic             ser_in_ready;
    logic             ser_in;
    logic             ser_out_valid;
    logic             ser_out_ready;
    logic             ser_out;

    logic [1:0]       sr_mode;
    logic [WIDTH-1:0] sr_datain;
    logic [WIDTH-1:0] sr_q;

    logic             busy;
    logic             done;

    // Environment side: command source, serial source/sink, shift register.
    modport master (
        output cmd_valid, cmd_op, cmd_count, cmd_data,
        output ser_in_valid, ser_in, ser_out_ready, sr_q,
        input  cmd_ready, ser_in_ready, ser_out_valid, ser_out,
        input  sr_mode, sr_datain, busy, done
    );

    // Sequencer side.
    modport slave (
        input  cmd_valid, cmd_op, cmd_count, cmd_data,
        input  ser_in_valid, ser_in, ser_out_ready, sr_q,
        output cmd_ready, ser_in_ready, ser_out_valid, ser_out,
        output sr_mode, sr_datain, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/usr_beat_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | usr_beat_counter : loadable down-counter with a last-beat flag.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module usr_beat_counter #(
    parameter int CNT_W = 4
) (
    input  wire logic             clock,
    input  wire logic             reset,
    input  wire logic             load,
    input  wire logic [CNT_W-1:0] load_val,
    input  wire logic             dec,
    output logic                  last
);
    logic [CNT_W-1:0] remaining_q;
    logic [CNT_W-1:0] remaining_d;

    // Saturates at zero so a stray decrement can never wrap.
    always_comb begin
        remaining_d = remaining_q;
        if (load) begin
            remaining_d = load_val;
        end else if (dec && (remaining_q != '0)) begin
            remaining_d = remaining_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            remaining_q <= '0;
        end else begin
            remaining_q <= remaining_d;
        end
    end

    assign last = (remaining_q == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/usr_seq_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | usr_seq_ctrl : command sequencer driving a universal shift       |
// |                register cycle by cycle, with flow-controlled     |
// |                serial in/out streams.                            |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module usr_seq_ctrl
    import usr_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 4
) (
    input  wire logic    clock,
    input  wire logic    reset,
    usr_seq_ctrl_if.slave bus
);
    state_t           state_q;
    state_t           state_d;
    logic [1:0]       op_q;
    logic [1:0]       op_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_last;
    logic             beat;

    logic             cmd_ready;
    logic             ser_in_ready;
    logic             ser_out_valid;
    logic             ser_out;
    logic [1:0]       sr_mode;
    logic [WIDTH-1:0] sr_datain;
    logic             busy;
    logic             done;

    usr_beat_counter #(
        .CNT_W (CNT_W)
    ) u_beat_counter (
        .clock    (clock),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (bus.cmd_count),
        .dec      (cnt_dec),
        .last     (cnt_last)
    );

    // A beat needs both a source bit and a sink slot in the same cycle.
    assign beat = bus.ser_in_valid && bus.ser_out_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        data_d        = data_q;
        cnt_load      = 1'b0;
        cnt_dec       = 1'b0;
        cmd_ready     = 1'b0;
        ser_in_ready  = 1'b0;
        ser_out_valid = 1'b0;
        ser_out       = 1'b0;
        sr_mode       = MODE_HOLD;
        sr_datain     = '0;
        busy          = 1'b1;
        done          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy      = 1'b0;
                cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    op_d     = bus.cmd_op;
                    data_d   = bus.cmd_data;
                    cnt_load = 1'b1;
                    if (bus.cmd_op == MODE_LOAD) begin
                        state_d = ST_LOAD;
                    end else if (bus.cmd_count == '0) begin
                        state_d = ST_DONE;
                    end else if (bus.cmd_op == MODE_HOLD) begin
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end

            ST_LOAD: begin
                sr_mode   = MODE_LOAD;
                sr_datain = data_q;
                state_d   = ST_DONE;
            end

            ST_SHIFT: begin
                // Each ready mirrors the opposite side's flag, never its own.
                ser_in_ready  = bus.ser_out_ready;
                ser_out_valid = bus.ser_in_valid;
                ser_out       = (op_q == MODE_SHR) ? bus.sr_q[0] : bus.sr_q[WIDTH-1];
                sr_datain[0]  = bus.ser_in;
                if (beat) begin
                    sr_mode = op_q;
                    cnt_dec = 1'b1;
                    if (cnt_last) begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_HOLD: begin
                cnt_dec = 1'b1;
                if (cnt_last) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.cmd_ready     = cmd_ready;
    assign bus.ser_in_ready  = ser_in_ready;
    assign bus.ser_out_valid = ser_out_valid;
    assign bus.ser_out       = ser_out;
    assign bus.sr_mode       = sr_mode;
    assign bus.sr_datain     = sr_datain;
    assign bus.busy          = busy;
    assign bus.done          = done;

endmodule
`default_nettype wire

// File: tb/tb_usr_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | tb_usr_seq_ctrl : randomized bench with a bit-queue reference    |
// |                   model of the register contents.                |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_usr_seq_ctrl;
    import usr_pkg::*;

    localparam int WIDTH = 4;
    localparam int CNT_W = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;

    usr_seq_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    usr_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Universal shift register; serial bit enters on DATAIN[0].
    logic [WIDTH-1:0] sr_reg = '0;
    always @(posedge clock) begin
        case (bus.sr_mode)
            MODE_SHR:  sr_reg <= {bus.sr_datain[0], sr_reg[WIDTH-1:1]};
            MODE_SHL:  sr_reg <= {sr_reg[WIDTH-2:0], bus.sr_datain[0]};
            MODE_LOAD: sr_reg <= bus.sr_datain;
            default:   sr_reg <= sr_reg;
        endcase
    end
    assign bus.sr_q = sr_reg;

    int n_tests = 0;
    int n_fail  = 0;

    // Register contents as a bit queue, index 0 = MSB.
    logic mq[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_word();
        logic [31:0] w = '0;
        for (int i = 0; i < WIDTH; i++) w[WIDTH-1-i] = mq[i];
        return w;
    endfunction

    task automatic model_load(input logic [WIDTH-1:0] d);
        mq.delete();
        for (int i = WIDTH-1; i >= 0; i--) mq.push_back(d[i]);
    endtask

    // Returns the bit that leaves the register.
    task automatic model_shift(input logic [1:0] op, input logic sin, output logic out);
        if (op == MODE_SHR) begin
            out = mq.pop_back();
            mq.push_front(sin);
        end else begin
            out = mq.pop_front();
            mq.push_back(sin);
        end
    endtask

    task automatic noise();
        bus.cmd_valid = 1'($urandom);
        bus.cmd_op    = 2'($urandom);
        bus.cmd_count = CNT_W'($urandom);
        bus.cmd_data  = WIDTH'($urandom);
    endtask

    // pct < 0 selects forced patterns: source always valid, sink ready per
    // rdy_mask bit (one per cycle), ser_in per sin_pat bit (one per beat).
    task automatic run_cmd(input logic [1:0] op, input logic [CNT_W-1:0] cnt,
                           input logic [WIDTH-1:0] data, input int pct,
                           input logic [31:0] rdy_mask, input logic [31:0] sin_pat);
        int   rem;
        int   cyc;
        logic v, r, sin, exp_out;
        @(negedge clock);
        bus.cmd_valid     = 1'b1;
        bus.cmd_op        = op;
        bus.cmd_count     = cnt;
        bus.cmd_data      = data;
        bus.ser_in_valid  = 1'($urandom);
        bus.ser_out_ready = 1'($urandom);
        bus.ser_in        = 1'($urandom);
        #1;
        check("accept_ready", 32'(bus.cmd_ready), 32'd1);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_done", 32'(bus.done), 32'd0);
        check("idle_mode", 32'(bus.sr_mode), 32'(MODE_HOLD));
        check("idle_sir", 32'(bus.ser_in_ready), 32'd0);
        check("idle_sov", 32'(bus.ser_out_valid), 32'd0);

        if (op == MODE_LOAD) begin
            @(negedge clock);
            noise();
            #1;
            check("load_mode", 32'(bus.sr_mode), 32'(MODE_LOAD));
            check("load_data", 32'(bus.sr_datain), 32'(data));
            check("load_busy", 32'(bus.busy), 32'd1);
            model_load(data);
        end else if (op != MODE_HOLD && cnt != '0) begin
            rem = int'(cnt);
            cyc = 0;
            while (rem > 0 && cyc < 400) begin
                @(negedge clock);
                noise();
                if (pct < 0) begin
                    v   = 1'b1;
                    r   = (cyc < 32) ? rdy_mask[cyc] : 1'b1;
                    sin = sin_pat[int'(cnt) - rem];
                end else begin
                    v   = ($urandom_range(99) < pct);
                    r   = ($urandom_range(99) < pct);
                    sin = 1'($urandom);
                end
                bus.ser_in_valid  = v;
                bus.ser_out_ready = r;
                bus.ser_in        = sin;
                #1;
                check("sh_sir", 32'(bus.ser_in_ready), 32'(r));
                check("sh_sov", 32'(bus.ser_out_valid), 32'(v));
                check("sh_done", 32'(bus.done), 32'd0);
                check("sh_busy", 32'(bus.busy), 32'd1);
                if (v && r) begin
                    model_shift(op, sin, exp_out);
                    check("sh_mode", 32'(bus.sr_mode), 32'(op));
                    check("sh_out", 32'(bus.ser_out), 32'(exp_out));
                    check("sh_din", 32'(bus.sr_datain), 32'(sin));
                    rem--;
                end else begin
                    check("stall_mode", 32'(bus.sr_mode), 32'(MODE_HOLD));
                end
                cyc++;
            end
            if (rem > 0) check("shift_timeout", 32'(rem), 32'd0);
        end else if (op == MODE_HOLD && cnt != '0) begin
            for (int i = 0; i < int'(cnt); i++) begin
                @(negedge clock);
                noise();
                bus.ser_in_valid  = 1'($urandom);
                bus.ser_out_ready = 1'($urandom);
                #1;
                check("hold_mode", 32'(bus.sr_mode), 32'(MODE_HOLD));
                check("hold_busy", 32'(bus.busy), 32'd1);
                check("hold_done", 32'(bus.done), 32'd0);
                check("hold_sir", 32'(bus.ser_in_ready), 32'd0);
            end
        end

        @(negedge clock);
        noise();
        bus.ser_in_valid  = 1'b1;
        bus.ser_out_ready = 1'b1;
        #1;
        check("done_pulse", 32'(bus.done), 32'd1);
        check("done_mode", 32'(bus.sr_mode), 32'(MODE_HOLD));
        check("done_ready", 32'(bus.cmd_ready), 32'd0);
        check("done_sir", 32'(bus.ser_in_ready), 32'd0);
        check("sr_q", 32'(bus.sr_q), model_word());
        bus.cmd_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] pat;
        logic        o;
        bus.cmd_valid     = 1'b0;
        bus.cmd_op        = '0;
        bus.cmd_count     = '0;
        bus.cmd_data      = '0;
        bus.ser_in_valid  = 1'b0;
        bus.ser_out_ready = 1'b0;
        bus.ser_in        = 1'b0;
        model_load('0);

        @(negedge clock);
        #1;
        check("rst_mode", 32'(bus.sr_mode), 32'(MODE_HOLD));
        check("rst_din", 32'(bus.sr_datain), 32'd0);
        check("rst_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_sout", 32'(bus.ser_out), 32'd0);
        reset = 1'b1;

        run_cmd(MODE_LOAD, 4'd0, 4'b1011, 100, '1, '0);
        check("load_final", 32'(sr_reg), 32'h0000000b);

        run_cmd(MODE_SHR, 4'd4, 4'b0000, -1, '1, 32'b1001);
        check("shr_final", 32'(sr_reg), 32'h00000009);

        run_cmd(MODE_LOAD, 4'd0, 4'b0110, 100, '1, '0);
        pat = 32'($urandom_range(0, 3));
        run_cmd(MODE_SHL, 4'd2, 4'b0000, -1, 32'b10001, pat);
        check("shl_final", 32'(sr_reg), 32'({2'b10, pat[0], pat[1]}));

        run_cmd(MODE_HOLD, 4'd5, 4'b0000, 100, '1, '0);
        run_cmd(MODE_LOAD, 4'd0, 4'b0101, 100, '1, '0);

        run_cmd(MODE_SHR, 4'd0, 4'b0000, 100, '1, '0);
        run_cmd(MODE_SHL, 4'd0, 4'b0000, 100, '1, '0);

        // Abort a SHR of 3 after its first beat.
        @(negedge clock);
        bus.cmd_valid     = 1'b1;
        bus.cmd_op        = MODE_SHR;
        bus.cmd_count     = 4'd3;
        bus.ser_in_valid  = 1'b0;
        bus.ser_out_ready = 1'b0;
        #1;
        check("abort_accept", 32'(bus.cmd_ready), 32'd1);
        @(negedge clock);
        bus.cmd_valid     = 1'b0;
        bus.ser_in_valid  = 1'b1;
        bus.ser_out_ready = 1'b1;
        bus.ser_in        = 1'b1;
        #1;
        model_shift(MODE_SHR, 1'b1, o);
        check("abort_beat_out", 32'(bus.ser_out), 32'(o));
        check("abort_beat_mode", 32'(bus.sr_mode), 32'(MODE_SHR));
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("abort_mode", 32'(bus.sr_mode), 32'(MODE_HOLD));
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_sir", 32'(bus.ser_in_ready), 32'd0);
        @(negedge clock);
        bus.ser_in_valid  = 1'b0;
        reset = 1'b1;
        #1;
        check("post_rst_ready", 32'(bus.cmd_ready), 32'd1);
        check("post_rst_busy", 32'(bus.busy), 32'd0);
        check("post_rst_done", 32'(bus.done), 32'd0);
        check("post_rst_q", 32'(bus.sr_q), model_word());

        run_cmd(MODE_SHL, 4'd15, 4'b0000, 70, '1, '0);
        run_cmd(MODE_HOLD, 4'd15, 4'b0000, 100, '1, '0);

        for (int k = 0; k < 40; k++) begin
            logic [1:0]       op;
            logic [CNT_W-1:0] cnt;
            op  = 2'($urandom);
            cnt = ($urandom_range(0, 5) == 0) ? '0 : CNT_W'($urandom);
            run_cmd(op, cnt, WIDTH'($urandom), int'($urandom_range(30, 100)), '1, '0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1);
    end

endmodule
`default_nettype wire
